// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 64-bit doubleword memory port between requester A
// (load/store stage) and requester B (debug/preload). It arbitrates round-robin
// and runs the sequence IDLE -> ACCESS -> RESP. An illegal access goes
// IDLE -> RESP.
//
// Ports
//   Clock_i, Reset_i          clock; asynchronous active-high reset
//   Req*_i, We*_i             request and write-enable per requester (A/B)
//   Addr*_i, WData*_i         byte address and write data per requester
//   Ack*_o, Err*_o, RData*_o  one-cycle completion pulse, reject flag, read data
//   Busy_o                    high whenever the sequencer is not idle
//   Mem*_o, MemReadData_i     registered memory strobes, address and data
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic        ReqA_i,
  input  logic        ReqB_i,
  input  logic        WeA_i,
  input  logic        WeB_i,
  input  logic [63:0] AddrA_i,
  input  logic [63:0] AddrB_i,
  input  logic [63:0] WDataA_i,
  input  logic [63:0] WDataB_i,
  output logic        AckA_o,
  output logic        AckB_o,
  output logic        ErrA_o,
  output logic        ErrB_o,
  output logic [63:0] RDataA_o,
  output logic [63:0] RDataB_o,
  output logic        Busy_o,
  output logic [63:0] MemAddress_o,
  output logic [63:0] MemWriteData_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  input  logic [63:0] MemReadData_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  // Highest legal doubleword address, formed at full width so that addresses
  // near 2^64 cannot wrap past the limit.
  localparam logic [63:0] MAX_ADDR = 64'(MEM_SIZE) - 64'd8;

  state_e      state_q;
  logic        last_b_q;   // 1: B was granted last (reset value, so A wins the first tie)
  logic        win_b_q;    // current winner is B
  logic        we_q;       // current access is a write
  logic        ack_a_q, ack_b_q, err_a_q, err_b_q;
  logic [63:0] rdata_a_q, rdata_b_q;
  logic [63:0] mem_addr_q, mem_wdata_q;
  logic        mem_rd_q, mem_wr_q;

  // Grant selection for the current IDLE cycle. On a tie, the requester that
  // was not granted last wins.
  logic        gnt_b_d;
  logic        we_d;
  logic [63:0] addr_d, wdata_d;
  logic        legal_d;

  assign gnt_b_d = ReqB_i & (~ReqA_i | ~last_b_q);
  assign we_d    = gnt_b_d ? WeB_i    : WeA_i;
  assign addr_d  = gnt_b_d ? AddrB_i  : AddrA_i;
  assign wdata_d = gnt_b_d ? WDataB_i : WDataA_i;
  assign legal_d = (addr_d[2:0] == 3'b000) && (addr_d <= MAX_ADDR);

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      win_b_q     <= 1'b0;
      we_q        <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ReqA_i || ReqB_i) begin
            win_b_q  <= gnt_b_d;
            last_b_q <= gnt_b_d;
            we_q     <= we_d;
            if (legal_d) begin
              // Memory strobes are registered so they are valid for the whole
              // ACCESS cycle.
              state_q     <= ACCESS;
              mem_addr_q  <= addr_d;
              mem_rd_q    <= ~we_d;
              mem_wr_q    <= we_d;
              mem_wdata_q <= we_d ? wdata_d : '0;
            end else begin
              // A rejected access never touches memory. It answers in the next cycle.
              state_q <= RESP;
              if (gnt_b_d) begin
                ack_b_q <= 1'b1;
                err_b_q <= 1'b1;
              end else begin
                ack_a_q <= 1'b1;
                err_a_q <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          if (win_b_q) begin
            ack_b_q <= 1'b1;
            if (!we_q) rdata_b_q <= MemReadData_i;
          end else begin
            ack_a_q <= 1'b1;
            if (!we_q) rdata_a_q <= MemReadData_i;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          ack_a_q   <= 1'b0;
          ack_b_q   <= 1'b0;
          err_a_q   <= 1'b0;
          err_b_q   <= 1'b0;
          rdata_a_q <= '0;
          rdata_b_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AckA_o         = ack_a_q;
  assign AckB_o         = ack_b_q;
  assign ErrA_o         = err_a_q;
  assign ErrB_o         = err_b_q;
  assign RDataA_o       = rdata_a_q;
  assign RDataB_o       = rdata_b_q;
  assign Busy_o         = (state_q != IDLE);
  assign MemAddress_o   = mem_addr_q;
  assign MemWriteData_o = mem_wdata_q;
  assign MemRead_o      = mem_rd_q;
  assign MemWrite_o     = mem_wr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ReqA = 1'b0, ReqB = 1'b0, WeA = 1'b0, WeB = 1'b0;
  logic [63:0] AddrA = '0, AddrB = '0, WDataA = '0, WDataB = '0;
  logic        AckA, AckB, ErrA, ErrB, Busy, MemRead, MemWrite;
  logic [63:0] RDataA, RDataB, MemAddress, MemWriteData, MemReadData;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_SIZE(1024)) dut (
    .Clock_i(clk), .Reset_i(rst),
    .ReqA_i(ReqA), .ReqB_i(ReqB), .WeA_i(WeA), .WeB_i(WeB),
    .AddrA_i(AddrA), .AddrB_i(AddrB), .WDataA_i(WDataA), .WDataB_i(WDataB),
    .AckA_o(AckA), .AckB_o(AckB), .ErrA_o(ErrA), .ErrB_o(ErrB),
    .RDataA_o(RDataA), .RDataB_o(RDataB), .Busy_o(Busy),
    .MemAddress_o(MemAddress), .MemWriteData_o(MemWriteData),
    .MemRead_o(MemRead), .MemWrite_o(MemWrite), .MemReadData_i(MemReadData)
  );

  // Doubleword memory model: the write commits at the edge that ends ACCESS,
  // and read data follows the address combinationally. The first clock loads
  // the preset contents.
  logic [63:0] mem [0:127];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 64'h0;
      mem[0]   <= 64'h1;
      mem[1]   <= 64'h6;
      mem_init <= 1'b1;
    end else if (MemWrite) begin
      mem[MemAddress[9:3]] <= MemWriteData;
    end
  end
  assign MemReadData = mem[MemAddress[9:3]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk1("rst_acka", AckA, 1'b0);    chk1("rst_ackb", AckB, 1'b0);
    chk1("rst_erra", ErrA, 1'b0);    chk1("rst_errb", ErrB, 1'b0);
    chk1("rst_busy", Busy, 1'b0);    chk1("rst_mrd", MemRead, 1'b0);
    chk1("rst_mwr", MemWrite, 1'b0);
    chk64("rst_rda", RDataA, 64'h0); chk64("rst_rdb", RDataB, 64'h0);
    chk64("rst_maddr", MemAddress, 64'h0);
    chk64("rst_mwd", MemWriteData, 64'h0);
    tick(); tick();
    rst = 1'b0;

    // Simultaneous requests after reset: A wins first, then held requests alternate
    ReqA = 1; WeA = 0; AddrA = 64'h0;
    ReqB = 1; WeB = 0; AddrB = 64'h8;
    tick();
    chk1("tie1_mrd", MemRead, 1'b1);
    chk64("tie1_addr", MemAddress, 64'h0);
    chk1("tie1_busy", Busy, 1'b1);
    tick();
    chk1("tie1_acka", AckA, 1'b1);
    chk64("tie1_rda", RDataA, 64'h1);
    chk1("tie1_ackb", AckB, 1'b0);
    chk64("tie1_rdb", RDataB, 64'h0);
    tick();
    chk1("tie1_idle", Busy, 1'b0);
    chk1("tie1_ackoff", AckA, 1'b0);
    tick();
    chk64("tie2_addr", MemAddress, 64'h8);
    chk1("tie2_mrd", MemRead, 1'b1);
    tick();
    chk1("tie2_ackb", AckB, 1'b1);
    chk64("tie2_rdb", RDataB, 64'h6);
    chk1("tie2_acka", AckA, 1'b0);
    chk64("tie2_rda", RDataA, 64'h0);
    tick();
    tick();
    chk64("tie3_addr", MemAddress, 64'h0);
    chk1("tie3_mrd", MemRead, 1'b1);
    ReqA = 0; ReqB = 0;
    tick();
    chk1("tie3_acka", AckA, 1'b1);
    chk1("tie3_ackb", AckB, 1'b0);
    tick();

    // A writes 0x0FFBEA7DEADBEEFF to 0x18, then reads it back
    ReqA = 1; WeA = 1; AddrA = 64'h18; WDataA = 64'h0FFB_EA7D_EADB_EEFF;
    tick();
    chk1("wr_mwr", MemWrite, 1'b1);
    chk1("wr_mrd", MemRead, 1'b0);
    chk64("wr_addr", MemAddress, 64'h18);
    chk64("wr_wd", MemWriteData, 64'h0FFB_EA7D_EADB_EEFF);
    ReqA = 0; WeA = 0; WDataA = '0;
    tick();
    chk1("wr_acka", AckA, 1'b1);
    chk1("wr_erra", ErrA, 1'b0);
    chk64("wr_rda", RDataA, 64'h0);
    chk1("wr_mwr_off", MemWrite, 1'b0);
    tick();
    chk1("wr_idle", Busy, 1'b0);
    ReqA = 1; WeA = 0; AddrA = 64'h18;
    tick();
    chk1("rd_acka_early", AckA, 1'b0);
    ReqA = 0;
    tick();
    chk1("rd_acka", AckA, 1'b1);
    chk1("rd_erra", ErrA, 1'b0);
    chk64("rd_rda", RDataA, 64'h0FFB_EA7D_EADB_EEFF);
    tick();
    chk1("rd_ackoff", AckA, 1'b0);
    chk64("rd_rdaoff", RDataA, 64'h0);

    // Misaligned read by B: rejected one cycle after sampling, no strobe
    ReqB = 1; WeB = 0; AddrB = 64'h13;
    tick();
    chk1("mis_ackb", AckB, 1'b1);
    chk1("mis_errb", ErrB, 1'b1);
    chk64("mis_rdb", RDataB, 64'h0);
    chk1("mis_mrd", MemRead, 1'b0);
    ReqB = 0;
    tick();
    chk1("mis_ackoff", AckB, 1'b0);
    chk1("mis_erroff", ErrB, 1'b0);
    chk1("mis_idle", Busy, 1'b0);

    // Range checks: top doubleword is legal, one past it and near-2^64 are not
    ReqA = 1; WeA = 0; AddrA = 64'h3F8;
    tick();
    chk1("top_mrd", MemRead, 1'b1);
    chk64("top_addr", MemAddress, 64'h3F8);
    ReqA = 0;
    tick();
    chk1("top_acka", AckA, 1'b1);
    chk1("top_erra", ErrA, 1'b0);
    tick();
    ReqA = 1; AddrA = 64'h400;
    tick();
    chk1("oor_acka", AckA, 1'b1);
    chk1("oor_erra", ErrA, 1'b1);
    chk1("oor_mrd", MemRead, 1'b0);
    ReqA = 0;
    tick();
    ReqA = 1; AddrA = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    chk1("wrap_acka", AckA, 1'b1);
    chk1("wrap_erra", ErrA, 1'b1);
    chk1("wrap_mrd", MemRead, 1'b0);
    chk64("wrap_rda", RDataA, 64'h0);
    ReqA = 0;
    tick();

    // Reset pulsed while the write to 0x20 is in ACCESS: no commit, no ack
    ReqA = 1; WeA = 1; AddrA = 64'h20; WDataA = 64'hAA;
    tick();
    chk1("rsta_mwr_pre", MemWrite, 1'b1);
    ReqA = 0; WeA = 0;
    rst = 1'b1;
    #1;
    chk1("rsta_mwr", MemWrite, 1'b0);
    chk1("rsta_busy", Busy, 1'b0);
    chk64("rsta_addr", MemAddress, 64'h0);
    chk64("rsta_wd", MemWriteData, 64'h0);
    chk1("rsta_acka", AckA, 1'b0);
    rst = 1'b0;
    tick();
    chk1("rsta_noack", AckA, 1'b0);
    chk1("rsta_idle", Busy, 1'b0);
    ReqA = 1; AddrA = 64'h20;
    tick();
    ReqA = 0;
    tick();
    chk1("rsta_rd_ack", AckA, 1'b1);
    chk64("rsta_rd_data", RDataA, 64'h0);
    tick();

    // Hold-over: ReqA stays high one cycle past AckA -> second access 3 cycles later
    ReqA = 1; WeA = 0; AddrA = 64'h18;
    tick();
    tick();
    chk1("hold_ack1", AckA, 1'b1);
    tick();
    chk1("hold_gap1", AckA, 1'b0);
    tick();
    chk1("hold_mrd2", MemRead, 1'b1);
    chk1("hold_gap2", AckA, 1'b0);
    ReqA = 0;
    tick();
    chk1("hold_ack2", AckA, 1'b1);
    chk64("hold_rd2", RDataA, 64'h0FFB_EA7D_EADB_EEFF);
    tick();
    chk1("hold_end", Busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
